// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: writeback, issue reservation, flush and N read ports.
// Signal names follow the register-file port list so bench and design read alike.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic                  wen_i;
  logic [AW-1:0]         rd_idx_i;
  logic [XLEN-1:0]       rd_data_i;
  logic                  reserve_i;
  logic [AW-1:0]         reserve_idx_i;
  logic                  flush_i;
  logic [NRD*AW-1:0]     rs_idx_i;
  logic [NRD*XLEN-1:0]   rs_data_o;
  logic [NRD-1:0]        rs_busy_o;
  logic [NREGS-1:0]      busy_o;

  modport master (
    output wen_i, rd_idx_i, rd_data_i, reserve_i, reserve_idx_i, flush_i, rs_idx_i,
    input  rs_data_o, rs_busy_o, busy_o
  );

  modport slave (
    input  wen_i, rd_idx_i, rd_data_i, reserve_i, reserve_idx_i, flush_i, rs_idx_i,
    output rs_data_o, rs_busy_o, busy_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with per-register busy scoreboard
// and optional same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  regfile_sb_if.slave bus
);

  localparam logic ZR_EN = (ZERO_REG != 0);
  localparam logic BP_EN = (BYPASS != 0);

  logic [XLEN-1:0]     regs_r [NREGS];
  logic [NREGS-1:0]    busy_r;
  logic [NREGS-1:0]    busy_nxt_s;
  logic                wr_ok_s;
  logic                res_ok_s;
  logic [AW-1:0]       ridx_s;
  logic                zero_hit_s;
  logic                byp_hit_s;
  logic [NRD*XLEN-1:0] rs_data_s;
  logic [NRD-1:0]      rs_busy_s;

  assign wr_ok_s  = bus.wen_i && !(ZR_EN && (bus.rd_idx_i == {AW{1'b0}}));
  assign res_ok_s = bus.reserve_i && !(ZR_EN && (bus.reserve_idx_i == {AW{1'b0}}));

  // Register array storage; x0 writes are already filtered by wr_ok_s.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.rd_idx_i] <= bus.rd_data_i;
    end
  end

  // Scoreboard next state: flush dominates, then write-release, then reserve.
  always_comb begin
    busy_nxt_s = busy_r;
    if (bus.flush_i) begin
      busy_nxt_s = {NREGS{1'b0}};
    end else begin
      if (wr_ok_s) begin
        busy_nxt_s[bus.rd_idx_i] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (res_ok_s) begin
        busy_nxt_s[bus.reserve_idx_i] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports: the forwarded value also clears busy since the data is here now.
  always_comb begin
    rs_data_s  = {(NRD*XLEN){1'b0}};
    rs_busy_s  = {NRD{1'b0}};
    ridx_s     = {AW{1'b0}};
    zero_hit_s = 1'b0;
    byp_hit_s  = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ridx_s     = bus.rs_idx_i[k*AW +: AW];
      zero_hit_s = ZR_EN && (ridx_s == {AW{1'b0}});
      byp_hit_s  = BP_EN && wr_ok_s && (bus.rd_idx_i == ridx_s);
      if (!reset_i || zero_hit_s) begin
        rs_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rs_busy_s[k]              = 1'b0;
      end else if (byp_hit_s) begin
        rs_data_s[k*XLEN +: XLEN] = bus.rd_data_i;
        rs_busy_s[k]              = 1'b0;
      end else begin
        rs_data_s[k*XLEN +: XLEN] = regs_r[ridx_s];
        rs_busy_s[k]              = busy_r[ridx_s];
      end
    end
  end

  assign bus.rs_data_o = rs_data_s;
  assign bus.rs_busy_o = rs_busy_s;
  assign bus.busy_o    = busy_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (zero-reg+bypass, and plain
// x0 without bypass) share stimulus; a monitor checks against a behavioural model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            w_en;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_data;
  logic            r_en;
  logic [AW-1:0]   r_idx;
  logic            fl;
  logic [AW-1:0]   p_idx [NRD];

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b0 ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b1 ();

  assign b0.wen_i = w_en;   assign b1.wen_i = w_en;
  assign b0.rd_idx_i = w_idx;   assign b1.rd_idx_i = w_idx;
  assign b0.rd_data_i = w_data; assign b1.rd_data_i = w_data;
  assign b0.reserve_i = r_en;   assign b1.reserve_i = r_en;
  assign b0.reserve_idx_i = r_idx; assign b1.reserve_idx_i = r_idx;
  assign b0.flush_i = fl;   assign b1.flush_i = fl;
  assign b0.rs_idx_i = {p_idx[1], p_idx[0]};
  assign b1.rs_idx_i = {p_idx[1], p_idx[0]};

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
    u_dut0 (.clk_i(clk), .reset_i(rst), .bus(b0));
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0), .BYPASS(0))
    u_dut1 (.clk_i(clk), .reset_i(rst), .bus(b1));

  // Reference state, indexed by instance: 0 = zero-reg+bypass, 1 = neither.
  logic [XLEN-1:0]  m_regs [2][NREGS];
  logic [NREGS-1:0] m_busy [2];

  typedef struct {
    int                  d;
    int                  cyc;
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      rb;
    logic [NREGS-1:0]    bv;
  } exp_t;

  exp_t q[$];
  event ev;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = '0;
      for (int i = 0; i < NREGS; i++) m_regs[d][i] = '0;
    end
  endtask

  task automatic push_checks();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit zr;
      bit bp;
      bit wok;
      zr  = (d == 0);
      bp  = (d == 0);
      wok = w_en && !(zr && w_idx == 5'd0);
      e.d = d; e.cyc = cyc; e.data = '0; e.rb = '0;
      e.bv = rst ? m_busy[d] : '0;
      for (int k = 0; k < NRD; k++) begin
        if (!rst || (zr && p_idx[k] == 5'd0)) begin
          e.data[k*XLEN +: XLEN] = 32'd0;
        end else if (bp && wok && w_idx == p_idx[k]) begin
          e.data[k*XLEN +: XLEN] = w_data;
        end else begin
          e.data[k*XLEN +: XLEN] = m_regs[d][p_idx[k]];
          e.rb[k] = m_busy[d][p_idx[k]];
        end
      end
      q.push_back(e);
    end
    -> ev;
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        bit zr;
        bit wok;
        zr  = (d == 0);
        wok = w_en && !(zr && w_idx == 5'd0);
        if (wok) m_regs[d][w_idx] = w_data;
        if (fl) begin
          m_busy[d] = '0;
        end else begin
          if (wok) m_busy[d][w_idx] = 1'b0;
          if (r_en && !(zr && r_idx == 5'd0)) m_busy[d][r_idx] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc_go(input logic wen, input logic [AW-1:0] widx, input logic [XLEN-1:0] wdata,
                        input logic ren, input logic [AW-1:0] ridx, input logic flush,
                        input logic [AW-1:0] i0, input logic [AW-1:0] i1);
    @(negedge clk);
    w_en = wen; w_idx = widx; w_data = wdata;
    r_en = ren; r_idx = ridx; fl = flush;
    p_idx[0] = i0; p_idx[1] = i1;
    #1 push_checks();
    @(posedge clk);
    model_edge();
    cyc++;
  endtask

  // Monitor: pops each expectation and compares it with the addressed instance.
  initial begin
    exp_t e;
    logic [NRD*XLEN-1:0] a_data;
    logic [NRD-1:0]      a_rb;
    logic [NREGS-1:0]    a_bv;
    forever begin
      @(ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        a_data = (e.d == 0) ? b0.rs_data_o : b1.rs_data_o;
        a_rb   = (e.d == 0) ? b0.rs_busy_o : b1.rs_busy_o;
        a_bv   = (e.d == 0) ? b0.busy_o    : b1.busy_o;
        n_checks += 3;
        if (a_data !== e.data) begin
          n_fail++;
          $display("FAIL rs_data dut%0d cyc %0d: got %h want %h", e.d, e.cyc, a_data, e.data);
        end
        if (a_rb !== e.rb) begin
          n_fail++;
          $display("FAIL rs_busy dut%0d cyc %0d: got %b want %b", e.d, e.cyc, a_rb, e.rb);
        end
        if (a_bv !== e.bv) begin
          n_fail++;
          $display("FAIL busy_vec dut%0d cyc %0d: got %h want %h", e.d, e.cyc, a_bv, e.bv);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; w_en = 1'b0; w_idx = '0; w_data = '0;
    r_en = 1'b0; r_idx = '0; fl = 1'b0; p_idx[0] = '0; p_idx[1] = '0;
    model_reset();

    // Reset held: activity on the inputs must be ignored, outputs zero.
    cyc_go(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    cyc_go(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b0, 5'd7, 5'd3);
    #2 rst = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      a = AW'(i);
      b = AW'(NREGS - i);
      cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, a, b);
    end

    // Write and read on two ports; x0 write.
    cyc_go(1'b1, 5'd3, 32'h0000_1337, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    cyc_go(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);

    // Bypass versus stored-only reads.
    cyc_go(1'b1, 5'd5, 32'h0000_000A, 1'b0, 5'd0, 1'b0, 5'd5, 5'd3);
    cyc_go(1'b1, 5'd5, 32'h0000_000B, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);

    // Scoreboard reserve, release, and simultaneous reserve+write.
    cyc_go(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    cyc_go(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    cyc_go(1'b1, 5'd7, 32'h0000_0066, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd7, 5'd0);

    // Flush with concurrent reserve and write.
    cyc_go(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd2);
    cyc_go(1'b1, 5'd2, 32'h0000_0077, 1'b1, 5'd4, 1'b1, 5'd2, 5'd4);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd4);

    // Asynchronous reset pulse between edges with x3 written and x7 busy.
    cyc_go(1'b1, 5'd3, 32'h0000_1337, 1'b1, 5'd7, 1'b0, 5'd3, 5'd7);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; fl = 1'b0; p_idx[0] = 5'd3; p_idx[1] = 5'd7;
    #1 push_checks();
    #1 rst = 1'b0;
    model_reset();
    #1 push_checks();
    #1 rst = 1'b1;
    @(posedge clk);
    cyc++;
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7);
    cyc_go(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3);

    // Randomized traffic biased to low indices so hazards collide often.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wi;
      logic [AW-1:0] ri;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      wi = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
      ri = AW'($urandom_range(0, 7));
      a  = AW'($urandom_range(0, 7));
      b  = ($urandom_range(0, 2) == 0) ? wi : AW'($urandom_range(0, 31));
      cyc_go(1'($urandom_range(0, 1)), wi, $urandom, 1'($urandom_range(0, 1)), ri,
             1'($urandom_range(0, 15) == 0), a, b);
    end

    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file with a per-register busy scoreboard and optional write-to-read bypass. It is the next-generation integer register file for the rv32 core pipeline. Decode reserves a destination register when an instruction issues. Writeback releases the register and commits its data. Operand fetch reads data and busy status on N ports in the same cycle.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of registers; power of two, minimum 2.
NRD, 2, number of read ports, 1..4.
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is an ordinary register.
BYPASS, 1, 1 = same-cycle write data forwards to matching read ports; 0 = reads see stored values only.
AW, $clog2(NREGS), index width (derived; do not override).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_i  in  1  asynchronous active-low reset.
wen_i  in  1  write enable (writeback).
rd_idx_i  in  AW  write index.
rd_data_i  in  XLEN  write data.
reserve_i  in  1  set busy on reserve_idx_i (issue).
reserve_idx_i  in  AW  index to reserve.
flush_i  in  1  clear all busy bits (pipeline flush).
rs_idx_i  in  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
rs_data_o  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
rs_busy_o  out  NRD  per-port busy status of the addressed register.
busy_o  out  NREGS  full scoreboard vector; bit i is register i.

Behaviour:
- Reset (reset_i=0, asynchronous): all registers clear to 0 and all busy bits clear to 0. While reset is held: rs_data_o=0, rs_busy_o=0, busy_o=0. Writes, reserves and flushes are ignored. Release on any cycle is clean: the first rising edge after release operates normally. Reset asserted mid-operation discards all state immediately; no edge is needed.
- Write: on a rising edge with wen_i=1, regs[rd_idx_i] <= rd_data_i. If ZERO_REG=1 and rd_idx_i=0, the write is dropped.
- Read: combinational, with zero latency from rs_idx_i to rs_data_o. Port k output:
  - 0 if ZERO_REG=1 and the index is 0;
  - otherwise rd_data_i if BYPASS=1, wen_i=1 and rd_idx_i equals the index (with the same zero-reg exclusion);
  - otherwise regs[index].
- With BYPASS=0, a written value becomes visible the cycle after the write edge.
- All read ports are independent. Any number of ports may address the same register.
- Scoreboard, per rising edge, in priority order:
  1. flush_i=1: every busy bit cleared; reserve_i in the same cycle is discarded. The data write still occurs.
  2. Otherwise, a write clears busy[rd_idx_i], then a reserve sets busy[reserve_idx_i]. If both target the same index, reserve wins and the bit ends at 1 (new producer issued).
  3. Reserve of index 0 with ZERO_REG=1 is ignored; busy_o[0] stays 0.
  4. Writing a non-busy register is legal and leaves its busy bit at 0.
  5. Reserving an already-busy register is legal and leaves it busy.
- rs_busy_o[k] = busy[idx_k], forced to 0 when:
  - ZERO_REG=1 and idx_k=0, or
  - BYPASS=1, wen_i=1 and rd_idx_i=idx_k (the value is available this cycle).
- With BYPASS=0, rs_busy_o follows busy only; a register written this cycle reports busy until the edge.
- busy_o reflects stored bits only, with no bypass masking.
- Widths: rd_data_i is stored unmodified. Indices are never out of range because NREGS=2^AW.

Test Plan:
- Reset and idle: hold reset_i=0 for 2 cycles, then release -> rs_data_o=0, rs_busy_o=0 and busy_o=0 on all ports; reading indices 1..31 returns 0.
- Write/read on two ports: write 0x1337 to x3, then set port0 and port1 idx=3 -> both return 0x1337 the next cycle. A write to x0 of 0xFFFF_FFFF -> x0 still reads 0 and busy_o[0]=0.
- Bypass: with x5=0xA, drive wen=1, rd=5, data=0xB, and read port0 idx=5 in the same cycle -> rs_data=0xB before the edge. With BYPASS=0, read 0xA before the edge and 0xB after it.
- Scoreboard: reserve x7 -> busy_o[7]=1 and rs_busy=1 at idx 7. Write x7 with 0x55 -> rs_busy=0 during the write cycle (BYPASS=1) and busy_o[7]=0 after the edge. Reserve and write x7 in the same cycle -> busy_o[7]=1 afterwards.
- Flush: reserve x1, x2 and x9, then flush_i=1 together with reserve x4 and a write of 0x77 to x2 -> busy_o=0 after the edge and x2 reads 0x77.
- Async reset mid-run: with x3=0x1337 and x7 busy, pulse reset_i low between clock edges -> outputs go to 0 immediately, before the next edge, and remain 0 after release until new writes.
